// File: rtl/vote_tally_pkg.sv
// Shared types and defaults for the ballot-entry / tally stage.
package vote_tally_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_D1     = 3'd1,
        ST_D2     = 3'd2,
        ST_REVIEW = 3'd3,
        ST_CLOSED = 3'd4
    } state_t;

    localparam logic [7:0] CODE_C1_DEF   = 8'h13;
    localparam logic [7:0] CODE_C2_DEF   = 8'h22;
    localparam int         MAX_VOTES_DEF = 255;
    localparam int         TIMEOUT_DEF   = 1000;

    localparam logic [3:0] BLANK_NIBBLE = 4'hF;
    localparam logic [7:0] ENTRY_BLANK  = {BLANK_NIBBLE, BLANK_NIBBLE};

    // Keypad codes 10..15 are not real digits.
    function automatic logic digit_ok(input logic [3:0] d);
        return d <= 4'd9;
    endfunction

endpackage

// File: rtl/vote_tally_if.sv
// Keypad/session inputs and tally/display outputs of the vote tally stage.
interface vote_tally_if;

    logic       open_session;
    logic       close_session;
    logic       digit_valid;
    logic [3:0] digit;
    logic       confirm;
    logic       cancel;

    logic [7:0] c1;
    logic [7:0] c2;
    logic [7:0] nulo;
    logic       start;
    logic       finish;
    logic       vote_ack;
    logic [7:0] entry;
    logic [2:0] state;

    modport master (
        output open_session, close_session, digit_valid, digit, confirm, cancel,
        input  c1, c2, nulo, start, finish, vote_ack, entry, state
    );

    modport slave (
        input  open_session, close_session, digit_valid, digit, confirm, cancel,
        output c1, c2, nulo, start, finish, vote_ack, entry, state
    );

endinterface

// File: rtl/vote_tally_sat_counter.sv
// 8-bit vote counter with synchronous clear and saturation at MAX.
module vote_tally_sat_counter #(
    parameter int MAX = 255
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       clr,
    input  logic       inc,
    output logic [7:0] cnt
);

    localparam logic [7:0] MAX_V = 8'(MAX);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= 8'd0;
        end else if (clr) begin
            cnt <= 8'd0;
        end else if (inc && (cnt != MAX_V)) begin
            cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/vote_tally.sv
// Ballot entry FSM and tally for two candidates plus invalid (nulo) votes.
//   state   | meaning
//   IDLE    | after reset, waiting for a session to open
//   D1      | waiting for first digit
//   D2      | first digit held, waiting for second
//   REVIEW  | full code shown, waiting for confirm/cancel
//   CLOSED  | session over, counts frozen, display in results mode
module vote_tally
    import vote_tally_pkg::*;
#(
    parameter logic [7:0] CODE_C1   = CODE_C1_DEF,
    parameter logic [7:0] CODE_C2   = CODE_C2_DEF,
    parameter int         MAX_VOTES = MAX_VOTES_DEF,
    parameter int         TIMEOUT   = TIMEOUT_DEF
) (
    input  logic         clock,
    input  logic         reset_n,
    vote_tally_if.slave  bus
);

    localparam int                TMR_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0]  TMR_LOAD = TMR_W'(TIMEOUT - 1);

    state_t           st;
    logic             open_q;
    logic             close_q;
    logic [7:0]       entry_r;
    logic [TMR_W-1:0] tmr;
    logic             start_r;
    logic             finish_r;
    logic             ack_r;

    logic open_rise;
    logic close_rise;
    logic digit_acc;
    logic commit;
    logic clr_cnt;
    logic inc_c1;
    logic inc_c2;
    logic inc_nulo;

    assign open_rise  = bus.open_session  & ~open_q;
    assign close_rise = bus.close_session & ~close_q;
    assign digit_acc  = bus.digit_valid & digit_ok(bus.digit);

    // Counters act in the same cycle the FSM takes the confirm branch.
    assign commit   = (st == ST_REVIEW) && !close_rise && !bus.cancel && bus.confirm;
    assign clr_cnt  = open_rise && ((st == ST_IDLE) || (st == ST_CLOSED));
    assign inc_c1   = commit && (entry_r == CODE_C1);
    assign inc_c2   = commit && (entry_r == CODE_C2);
    assign inc_nulo = commit && (entry_r != CODE_C1) && (entry_r != CODE_C2);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            st       <= ST_IDLE;
            open_q   <= 1'b0;
            close_q  <= 1'b0;
            entry_r  <= ENTRY_BLANK;
            tmr      <= '0;
            start_r  <= 1'b0;
            finish_r <= 1'b0;
            ack_r    <= 1'b0;
        end else begin
            open_q  <= bus.open_session;
            close_q <= bus.close_session;
            start_r <= 1'b0;
            ack_r   <= 1'b0;
            case (st)
                ST_IDLE, ST_CLOSED: begin
                    if (open_rise) begin
                        st       <= ST_D1;
                        start_r  <= 1'b1;
                        finish_r <= 1'b0;
                        entry_r  <= ENTRY_BLANK;
                    end
                end
                ST_D1: begin
                    if (close_rise) begin
                        st       <= ST_CLOSED;
                        finish_r <= 1'b1;
                        entry_r  <= ENTRY_BLANK;
                    end else if (!bus.cancel && !bus.confirm && digit_acc) begin
                        st      <= ST_D2;
                        entry_r <= {bus.digit, BLANK_NIBBLE};
                        tmr     <= TMR_LOAD;
                    end
                end
                ST_D2: begin
                    if (close_rise) begin
                        st       <= ST_CLOSED;
                        finish_r <= 1'b1;
                        entry_r  <= ENTRY_BLANK;
                    end else if (bus.cancel) begin
                        st      <= ST_D1;
                        entry_r <= ENTRY_BLANK;
                    end else if (!bus.confirm && digit_acc) begin
                        st      <= ST_REVIEW;
                        entry_r <= {entry_r[7:4], bus.digit};
                        tmr     <= TMR_LOAD;
                    end else if (tmr == '0) begin
                        st      <= ST_D1;
                        entry_r <= ENTRY_BLANK;
                    end else begin
                        tmr <= tmr - TMR_W'(1);
                    end
                end
                ST_REVIEW: begin
                    if (close_rise) begin
                        st       <= ST_CLOSED;
                        finish_r <= 1'b1;
                        entry_r  <= ENTRY_BLANK;
                    end else if (bus.cancel) begin
                        st      <= ST_D1;
                        entry_r <= ENTRY_BLANK;
                    end else if (bus.confirm) begin
                        st      <= ST_D1;
                        entry_r <= ENTRY_BLANK;
                        ack_r   <= 1'b1;
                    end else if (tmr == '0) begin
                        st      <= ST_D1;
                        entry_r <= ENTRY_BLANK;
                    end else begin
                        tmr <= tmr - TMR_W'(1);
                    end
                end
                default: begin
                    st       <= ST_IDLE;
                    finish_r <= 1'b0;
                    entry_r  <= ENTRY_BLANK;
                end
            endcase
        end
    end

    vote_tally_sat_counter #(.MAX(MAX_VOTES)) u_cnt_c1 (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     (clr_cnt),
        .inc     (inc_c1),
        .cnt     (bus.c1)
    );

    vote_tally_sat_counter #(.MAX(MAX_VOTES)) u_cnt_c2 (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     (clr_cnt),
        .inc     (inc_c2),
        .cnt     (bus.c2)
    );

    vote_tally_sat_counter #(.MAX(MAX_VOTES)) u_cnt_nulo (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     (clr_cnt),
        .inc     (inc_nulo),
        .cnt     (bus.nulo)
    );

    assign bus.state    = st;
    assign bus.entry    = entry_r;
    assign bus.start    = start_r;
    assign bus.finish   = finish_r;
    assign bus.vote_ack = ack_r;

endmodule
